// File: rtl/nnrv_wb_arb.sv
// nnrv_wb_arb: writeback arbiter and register scoreboard.
// Two producers share the register file's single write port. Requester 0 is
// the ALU and requester 1 is the LSU, arbitrated round-robin. A busy bit per
// destination register raises an issue-stage stall on RAW and WAW hazards.
// Optional macro NNRV_WB_FWD_EN forwards the write-stage data to the issue
// stage and masks the matching RAW stall terms.
module nnrv_wb_arb #(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req0_valid,
  input  logic [4:0]      i_req0_rd,
  input  logic [XLEN-1:0] i_req0_data,
  output logic            o_req0_ready,
  input  logic            i_req1_valid,
  input  logic [4:0]      i_req1_rd,
  input  logic [XLEN-1:0] i_req1_data,
  output logic            o_req1_ready,
  input  logic            i_issue_en,
  input  logic [4:0]      i_issue_rd,
  input  logic            i_r1_en,
  input  logic [4:0]      i_r1,
  input  logic            i_r2_en,
  input  logic [4:0]      i_r2,
  output logic            o_stall,
  output logic            o_w_en,
  output logic [4:0]      o_w,
  output logic [XLEN-1:0] o_w_reg,
  output logic            o_fwd1_valid,
  output logic            o_fwd2_valid,
  output logic [XLEN-1:0] o_fwd_data,
  output logic            o_idle
);

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_e;

  req_e               r_rr_last;
  logic               r_w_en;
  logic [4:0]         r_w;
  logic [XLEN-1:0]    r_w_reg;
  logic [REG_NUM-1:0] r_busy;
  logic [REG_NUM-1:0] w_busy_nxt;
  logic               w_gnt0;
  logic               w_gnt1;
  logic               w_fwd1;
  logic               w_fwd2;

  // Round-robin grant; no grant while reset is applied, so a pending valid
  // is re-arbitrated once reset releases.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!i_rst) begin
      if (i_req0_valid && i_req1_valid) begin
        w_gnt0 = (r_rr_last == REQ1);
        w_gnt1 = (r_rr_last == REQ0);
      end else begin
        w_gnt0 = i_req0_valid;
        w_gnt1 = i_req1_valid;
      end
    end
  end

  assign o_req0_ready = w_gnt0;
  assign o_req1_ready = w_gnt1;

  // Last-winner register; holds when nothing is granted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_last <= REQ1;
    end else if (w_gnt0) begin
      r_rr_last <= REQ0;
    end else if (w_gnt1) begin
      r_rr_last <= REQ1;
    end
  end

  // Write stage: one-cycle pipeline from grant to register file write port.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_w_en  <= 1'b0;
      r_w     <= '0;
      r_w_reg <= '0;
    end else if (w_gnt0) begin
      r_w_en  <= (i_req0_rd != 5'd0);
      r_w     <= i_req0_rd;
      r_w_reg <= i_req0_data;
    end else if (w_gnt1) begin
      r_w_en  <= (i_req1_rd != 5'd0);
      r_w     <= i_req1_rd;
      r_w_reg <= i_req1_data;
    end else begin
      r_w_en  <= 1'b0;
    end
  end

  assign o_w_en  = r_w_en;
  assign o_w     = r_w;
  assign o_w_reg = r_w_reg;

  // Scoreboard update: clear the written register, then apply the issue set
  // so a same-edge set of the same register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_w_en) begin
      w_busy_nxt[r_w] = 1'b0;
    end
    if (i_issue_en && (i_issue_rd != 5'd0)) begin
      w_busy_nxt[i_issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

`ifdef NNRV_WB_FWD_EN
  assign w_fwd1     = r_w_en && i_r1_en && (i_r1 == r_w) && (r_w != 5'd0);
  assign w_fwd2     = r_w_en && i_r2_en && (i_r2 == r_w) && (r_w != 5'd0);
  assign o_fwd_data = r_w_reg;
`else
  assign w_fwd1     = 1'b0;
  assign w_fwd2     = 1'b0;
  assign o_fwd_data = '0;
`endif

  assign o_fwd1_valid = w_fwd1;
  assign o_fwd2_valid = w_fwd2;

  // Hazard stall: RAW terms are masked by a forward hit, WAW never is.
  always_comb begin
    o_stall = (i_r1_en && r_busy[i_r1] && !w_fwd1)
           || (i_r2_en && r_busy[i_r2] && !w_fwd2)
           || (i_issue_en && r_busy[i_issue_rd]);
  end

  assign o_idle = (r_busy == '0) && !r_w_en;

endmodule

// File: tb/tb_nnrv_wb_arb.sv
// Testbench for nnrv_wb_arb: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_nnrv_wb_arb;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req0_valid;
  logic [4:0]  i_req0_rd;
  logic [31:0] i_req0_data;
  logic        o_req0_ready;
  logic        i_req1_valid;
  logic [4:0]  i_req1_rd;
  logic [31:0] i_req1_data;
  logic        o_req1_ready;
  logic        i_issue_en;
  logic [4:0]  i_issue_rd;
  logic        i_r1_en;
  logic [4:0]  i_r1;
  logic        i_r2_en;
  logic [4:0]  i_r2;
  logic        o_stall;
  logic        o_w_en;
  logic [4:0]  o_w;
  logic [31:0] o_w_reg;
  logic        o_fwd1_valid;
  logic        o_fwd2_valid;
  logic [31:0] o_fwd_data;
  logic        o_idle;

  int checks   = 0;
  int failures = 0;

  nnrv_wb_arb #(.XLEN(32), .REG_NUM(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0_valid(i_req0_valid), .i_req0_rd(i_req0_rd), .i_req0_data(i_req0_data),
    .o_req0_ready(o_req0_ready),
    .i_req1_valid(i_req1_valid), .i_req1_rd(i_req1_rd), .i_req1_data(i_req1_data),
    .o_req1_ready(o_req1_ready),
    .i_issue_en(i_issue_en), .i_issue_rd(i_issue_rd),
    .i_r1_en(i_r1_en), .i_r1(i_r1), .i_r2_en(i_r2_en), .i_r2(i_r2),
    .o_stall(o_stall), .o_w_en(o_w_en), .o_w(o_w), .o_w_reg(o_w_reg),
    .o_fwd1_valid(o_fwd1_valid), .o_fwd2_valid(o_fwd2_valid),
    .o_fwd_data(o_fwd_data), .o_idle(o_idle)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit        m_en = 1'b0;
  int        m_last = 1;          // index of last granted requester
  bit        m_busy[32];
  bit        m_wv;                // a real (rd!=0) write is presented this cycle
  int        m_wrd;
  bit [31:0] m_wdata;

  function automatic int pick_winner(input bit rst, input bit v0, input bit v1);
    if (rst) return -1;
    if (v0 && v1) return 1 - m_last;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  always @(posedge i_clk) begin
    int g;
    if (i_rst) begin
      m_en = 1'b1;
      m_last = 1;
      m_wv = 1'b0;
      foreach (m_busy[k]) m_busy[k] = 1'b0;
    end else begin
      if (m_wv) m_busy[m_wrd] = 1'b0;
      if (i_issue_en && i_issue_rd != 0) m_busy[i_issue_rd] = 1'b1;
      g = pick_winner(1'b0, i_req0_valid, i_req1_valid);
      m_wv = 1'b0;
      if (g == 0) begin
        m_wv = (i_req0_rd != 0); m_wrd = i_req0_rd; m_wdata = i_req0_data; m_last = 0;
      end else if (g == 1) begin
        m_wv = (i_req1_rd != 0); m_wrd = i_req1_rd; m_wdata = i_req1_data; m_last = 1;
      end
    end
  end

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge i_clk) begin
    int  g;
    bit  f1, f2, st, any_busy;
    if (m_en) begin
      g = pick_winner(i_rst, i_req0_valid, i_req1_valid);
      chk("m_ready0", {31'd0, o_req0_ready}, {31'd0, g == 0});
      chk("m_ready1", {31'd0, o_req1_ready}, {31'd0, g == 1});
      chk("m_w_en", {31'd0, o_w_en}, {31'd0, m_wv});
      if (m_wv) begin
        chk("m_w", {27'd0, o_w}, m_wrd);
        chk("m_w_reg", o_w_reg, m_wdata);
      end
`ifdef NNRV_WB_FWD_EN
      f1 = m_wv && i_r1_en && (i_r1 == m_wrd);
      f2 = m_wv && i_r2_en && (i_r2 == m_wrd);
      if (m_wv) chk("m_fwd_data", o_fwd_data, m_wdata);
`else
      f1 = 1'b0;
      f2 = 1'b0;
      chk("m_fwd_data", o_fwd_data, 32'd0);
`endif
      chk("m_fwd1", {31'd0, o_fwd1_valid}, {31'd0, f1});
      chk("m_fwd2", {31'd0, o_fwd2_valid}, {31'd0, f2});
      st = (i_r1_en && m_busy[i_r1] && !f1) || (i_r2_en && m_busy[i_r2] && !f2)
        || (i_issue_en && m_busy[i_issue_rd]);
      chk("m_stall", {31'd0, o_stall}, {31'd0, st});
      any_busy = 1'b0;
      foreach (m_busy[k]) if (m_busy[k]) any_busy = 1'b1;
      chk("m_idle", {31'd0, o_idle}, {31'd0, !any_busy && !m_wv});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    cyc();
    i_rst = 1'b0;
  endtask

  initial begin
    bit g0, g1;
    i_rst = 1'b1;
    i_req0_valid = 0; i_req0_rd = 0; i_req0_data = 0;
    i_req1_valid = 0; i_req1_rd = 0; i_req1_data = 0;
    i_issue_en = 0; i_issue_rd = 0;
    i_r1_en = 0; i_r1 = 0; i_r2_en = 0; i_r2 = 0;
    cyc(); cyc();
    i_rst = 1'b0;

    // Reset state
    @(negedge i_clk);
    chk("rst_w_en", {31'd0, o_w_en}, 32'd0);
    chk("rst_w", {27'd0, o_w}, 32'd0);
    chk("rst_w_reg", o_w_reg, 32'd0);
    chk("rst_idle", {31'd0, o_idle}, 32'd1);
    chk("rst_stall", {31'd0, o_stall}, 32'd0);

    // Issue rd=5, single ALU writeback
    cyc();
    i_issue_en = 1; i_issue_rd = 5;
    @(negedge i_clk);
    cyc();
    i_issue_en = 0;
    i_req0_valid = 1; i_req0_rd = 5; i_req0_data = 32'hDEADBEEF;
    @(negedge i_clk);
    chk("t1_ready0", {31'd0, o_req0_ready}, 32'd1);
    cyc();
    i_req0_valid = 0;
    @(negedge i_clk);
    chk("t1_w_en", {31'd0, o_w_en}, 32'd1);
    chk("t1_w", {27'd0, o_w}, 32'd5);
    chk("t1_w_reg", o_w_reg, 32'hDEADBEEF);
    chk("t1_idle_busy", {31'd0, o_idle}, 32'd0);
    cyc();
    i_r1_en = 1; i_r1 = 5;
    @(negedge i_clk);
    chk("t1_idle", {31'd0, o_idle}, 32'd1);
    chk("t1_no_stall", {31'd0, o_stall}, 32'd0);
    cyc();
    i_r1_en = 0;

    // Both requesters valid continuously: alternate starting with 0
    do_reset();
    i_req0_valid = 1; i_req0_rd = 1; i_req0_data = 32'h11;
    i_req1_valid = 1; i_req1_rd = 2; i_req1_data = 32'h22;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      chk("t2_ready0", {31'd0, o_req0_ready}, {31'd0, (k % 2) == 0});
      chk("t2_ready1", {31'd0, o_req1_ready}, {31'd0, (k % 2) == 1});
      if (k >= 1) chk("t2_w", {27'd0, o_w}, ((k % 2) == 1) ? 32'd1 : 32'd2);
      cyc();
    end
    i_req0_valid = 0; i_req1_valid = 0;
    cyc(); cyc();

    // RAW stall on r7, released by the LSU writeback
    do_reset();
    i_issue_en = 1; i_issue_rd = 7;
    @(negedge i_clk);
    cyc();
    i_issue_en = 0; i_r1_en = 1; i_r1 = 7;
    @(negedge i_clk);
    chk("t3_stall_a", {31'd0, o_stall}, 32'd1);
    cyc();
    i_req1_valid = 1; i_req1_rd = 7; i_req1_data = 32'h77;
    @(negedge i_clk);
    chk("t3_ready1", {31'd0, o_req1_ready}, 32'd1);
    chk("t3_stall_b", {31'd0, o_stall}, 32'd1);
    cyc();
    i_req1_valid = 0;
    @(negedge i_clk);
    chk("t3_w_en", {31'd0, o_w_en}, 32'd1);
`ifdef NNRV_WB_FWD_EN
    chk("t3_stall_wr", {31'd0, o_stall}, 32'd0);
    chk("t3_fwd1", {31'd0, o_fwd1_valid}, 32'd1);
    chk("t3_fwd_data", o_fwd_data, 32'h77);
`else
    chk("t3_stall_wr", {31'd0, o_stall}, 32'd1);
    chk("t3_fwd1", {31'd0, o_fwd1_valid}, 32'd0);
`endif
    cyc();
    @(negedge i_clk);
    chk("t3_stall_after", {31'd0, o_stall}, 32'd0);
    cyc();
    i_r1_en = 0;

    // Write to r0: handshake completes, no write, no stall on r0
    i_req0_valid = 1; i_req0_rd = 0; i_req0_data = 32'h1234;
    i_r1_en = 1; i_r1 = 0;
    @(negedge i_clk);
    chk("t4_ready0", {31'd0, o_req0_ready}, 32'd1);
    chk("t4_stall", {31'd0, o_stall}, 32'd0);
    cyc();
    i_req0_valid = 0;
    @(negedge i_clk);
    chk("t4_w_en", {31'd0, o_w_en}, 32'd0);
    chk("t4_idle", {31'd0, o_idle}, 32'd1);
    cyc();
    i_r1_en = 0;

    // Same-edge set and clear of r9: set wins
    i_issue_en = 1; i_issue_rd = 9;
    @(negedge i_clk);
    cyc();
    i_issue_en = 0;
    i_req0_valid = 1; i_req0_rd = 9; i_req0_data = 32'h99;
    @(negedge i_clk);
    chk("t5_ready0", {31'd0, o_req0_ready}, 32'd1);
    cyc();
    i_req0_valid = 0; i_issue_en = 1; i_issue_rd = 9;
    @(negedge i_clk);
    chk("t5_w", {27'd0, o_w}, 32'd9);
    chk("t5_waw", {31'd0, o_stall}, 32'd1);
    cyc();
    i_issue_en = 0; i_r1_en = 1; i_r1 = 9;
    @(negedge i_clk);
    chk("t5_stall_r9", {31'd0, o_stall}, 32'd1);
    chk("t5_idle", {31'd0, o_idle}, 32'd0);
    cyc();
    i_r1_en = 0;

    // Reset mid-operation with a pending LSU request
    i_issue_en = 1; i_issue_rd = 3;
    @(negedge i_clk);
    cyc();
    i_issue_rd = 4;
    @(negedge i_clk);
    cyc();
    i_issue_en = 0; i_rst = 1;
    i_req1_valid = 1; i_req1_rd = 3; i_req1_data = 32'h33;
    i_r1_en = 1; i_r1 = 3;
    @(negedge i_clk);
    chk("t6_ready_in_rst", {31'd0, o_req1_ready}, 32'd0);
    cyc();
    i_rst = 0;
    @(negedge i_clk);
    chk("t6_w_en", {31'd0, o_w_en}, 32'd0);
    chk("t6_stall", {31'd0, o_stall}, 32'd0);
    chk("t6_idle", {31'd0, o_idle}, 32'd1);
    chk("t6_ready1", {31'd0, o_req1_ready}, 32'd1);
    cyc();
    i_req1_valid = 0;
    @(negedge i_clk);
    chk("t6_w", {27'd0, o_w}, 32'd3);
    cyc();
    i_r1_en = 0;

    // Randomized traffic; requesters hold valid/rd/data until granted
    for (int n = 0; n < 3000; n++) begin
      @(negedge i_clk);
      g0 = i_req0_valid && o_req0_ready;
      g1 = i_req1_valid && o_req1_ready;
      cyc();
      i_rst = ($urandom_range(0, 99) == 0);
      if (!i_req0_valid || g0) begin
        i_req0_valid = ($urandom_range(0, 2) != 0);
        i_req0_rd = 5'($urandom_range(0, 7));
        i_req0_data = $urandom;
      end
      if (!i_req1_valid || g1) begin
        i_req1_valid = ($urandom_range(0, 2) != 0);
        i_req1_rd = 5'($urandom_range(0, 7));
        i_req1_data = $urandom;
      end
      i_issue_en = ($urandom_range(0, 2) == 0);
      i_issue_rd = 5'($urandom_range(0, 7));
      i_r1_en = $urandom_range(0, 1) != 0;
      i_r1 = 5'($urandom_range(0, 7));
      i_r2_en = $urandom_range(0, 1) != 0;
      i_r2 = 5'($urandom_range(0, 7));
    end
    i_rst = 0;
    i_req0_valid = 0; i_req1_valid = 0;
    i_issue_en = 0; i_r1_en = 0; i_r2_en = 0;
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
